// File: rtl/snes_pad_pkg.sv
// Shared types and constants for the SNES pad reader and its per-pad channels.
package snes_pad_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LOW,
        CLK_HIGH,
        DONE
    } padState_t;

    // Width of one pad's serial word.
    localparam int PAD_BITS = 16;

    // Button bit positions within a button word (1 = pressed).
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // First of the top bits that a real pad always reports as released.
    localparam int ID_LSB = 12;

    // A connected pad reports bits 12..15 released; a pulled-down (unplugged)
    // line makes every bit look pressed.
    function automatic logic isPresent(input logic [PAD_BITS-1:0] raw);
        return raw[PAD_BITS-1:ID_LSB] == '0;
    endfunction

endpackage

// File: rtl/pad_channel.sv
// One pad's data path: input synchronizer, serial capture register and the
// published button / presence / sticky new-press state.
module pad_channel
    import snes_pad_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                padData,
    input  logic                sampleStrobe,
    input  logic                commitStrobe,
    input  logic                pressClr,
    output logic [PAD_BITS-1:0] buttons,
    output logic [PAD_BITS-1:0] press,
    output logic                present
);

    logic [1:0]          syncReg;
    logic                padSync;
    logic [PAD_BITS-1:0] shiftReg;
    logic [PAD_BITS-1:0] raw;
    logic [PAD_BITS-1:0] nextButtons;
    logic [PAD_BITS-1:0] nextPress;
    logic                nextPresent;

    // Two-flop synchronizer for the asynchronous pad line; idles released (high).
    always_ff @(posedge clk) begin
        // NOTE: registered state always uses non-blocking assignment so every
        // flop samples pre-edge values regardless of block ordering.
        if (!reset) begin
            syncReg <= 2'b11;
        end else begin
            syncReg <= {syncReg[0], padData};
        end
    end

    assign padSync = syncReg[1];

    // Serial capture: bit k arrives on the k-th sample strobe and shifts in
    // from the top, so after a full frame bit 0 sits at position 0.
    always_ff @(posedge clk) begin
        // NOTE: the capture register is reset only to keep it out of X; every
        // frame overwrites all of its bits before they are ever committed.
        if (!reset) begin
            shiftReg <= '1;
        end else if (sampleStrobe) begin
            shiftReg <= {padSync, shiftReg[PAD_BITS-1:1]};
        end
    end

    // Decode the captured word and build the next published state.
    always_comb begin
        // NOTE: every combinational output gets a value on every path here,
        // otherwise synthesis would infer a latch to hold the old one.
        raw         = ~shiftReg;
        nextPresent = isPresent(raw);
        nextButtons = nextPresent ? raw : '0;
        nextPress   = press & ~{PAD_BITS{pressClr}};
        if (commitStrobe) begin
            nextPress = nextPress | (nextButtons & ~buttons);
        end
    end

    // Published outputs: press clears any cycle, frame results land only on commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            buttons <= '0;
            press   <= '0;
            present <= 1'b0;
        end else begin
            press <= nextPress;
            if (commitStrobe) begin
                buttons <= nextButtons;
                present <= nextPresent;
            end
        end
    end

endmodule

// File: rtl/snes_pad_reader.sv
// Polls two SNES pads at a fixed rate: one frame sequencer drives the shared
// latch / shift clock and strobes both channels to sample and commit.
module snes_pad_reader
    import snes_pad_pkg::*;
#(
    parameter int POLL_DIV     = 416667,
    parameter int LATCH_CYCLES = 300,
    parameter int HALF_CYCLES  = 150,
    parameter int NUM_BITS     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [15:0] buttons0,
    output logic [15:0] buttons1,
    output logic [1:0]  pad_present,
    output logic [15:0] press0,
    output logic [15:0] press1,
    input  logic [1:0]  press_clr,
    output logic        frame_done
);

    localparam int POLL_W    = $clog2(POLL_DIV);
    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int BIT_W     = $clog2(NUM_BITS + 1);

    padState_t          state;
    logic [POLL_W-1:0]  pollCount;
    logic               pollWrap;
    logic [PHASE_W-1:0] phaseCount;
    logic [BIT_W-1:0]   bitIdx;
    logic               phaseLast;
    logic               sampleStrobe;
    logic               commitStrobe;

    assign pollWrap     = (pollCount == POLL_W'(POLL_DIV - 1));
    assign phaseLast    = (phaseCount == '0);
    assign sampleStrobe = phaseLast && ((state == LATCH) || (state == CLK_HIGH));
    assign commitStrobe = (state == DONE);

    // Free-running poll divider; its wrap requests a new frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pollCount <= '0;
        end else if (pollWrap) begin
            pollCount <= '0;
        end else begin
            pollCount <= pollCount + 1'b1;
        end
    end

    // Frame sequencer with registered pad_latch / pad_clk / frame_done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            phaseCount <= '0;
            bitIdx     <= '0;
            pad_latch  <= 1'b0;
            pad_clk    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A wrap seen in any other state is dropped on purpose.
                    if (pollWrap) begin
                        state      <= LATCH;
                        pad_latch  <= 1'b1;
                        phaseCount <= PHASE_W'(LATCH_CYCLES - 1);
                    end
                end
                LATCH: begin
                    if (phaseLast) begin
                        state      <= CLK_LOW;
                        pad_latch  <= 1'b0;
                        pad_clk    <= 1'b0;
                        bitIdx     <= BIT_W'(1);
                        phaseCount <= PHASE_W'(HALF_CYCLES - 1);
                    end else begin
                        phaseCount <= phaseCount - 1'b1;
                    end
                end
                CLK_LOW: begin
                    if (phaseLast) begin
                        state      <= CLK_HIGH;
                        pad_clk    <= 1'b1;
                        phaseCount <= PHASE_W'(HALF_CYCLES - 1);
                    end else begin
                        phaseCount <= phaseCount - 1'b1;
                    end
                end
                CLK_HIGH: begin
                    if (phaseLast) begin
                        if (bitIdx == BIT_W'(NUM_BITS - 1)) begin
                            state <= DONE;
                        end else begin
                            state      <= CLK_LOW;
                            pad_clk    <= 1'b0;
                            bitIdx     <= bitIdx + 1'b1;
                            phaseCount <= PHASE_W'(HALF_CYCLES - 1);
                        end
                    end else begin
                        phaseCount <= phaseCount - 1'b1;
                    end
                end
                DONE: begin
                    // Channels commit on this same edge, so the pulse lines up
                    // with the freshly published words.
                    state      <= IDLE;
                    frame_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pad_channel u_pad0 (
        .clk          (clk),
        .reset        (reset),
        .padData      (pad_data[0]),
        .sampleStrobe (sampleStrobe),
        .commitStrobe (commitStrobe),
        .pressClr     (press_clr[0]),
        .buttons      (buttons0),
        .press        (press0),
        .present      (pad_present[0])
    );

    pad_channel u_pad1 (
        .clk          (clk),
        .reset        (reset),
        .padData      (pad_data[1]),
        .sampleStrobe (sampleStrobe),
        .commitStrobe (commitStrobe),
        .pressClr     (press_clr[1]),
        .buttons      (buttons1),
        .press        (press1),
        .present      (pad_present[1])
    );

endmodule

// File: tb/tb_snes_pad_reader.sv
// Scoreboard bench for snes_pad_reader: behavioural pad models, directed frames
// with hand-computed results, and a monitor that checks every frame_done.
module tb_snes_pad_reader;

    localparam int POLL_DIV     = 2000;
    localparam int LATCH_CYCLES = 4;
    localparam int HALF_CYCLES  = 2;
    localparam int NUM_BITS     = 16;
    localparam int FRAME_LEN    = 65;   // 4 + 2*15*2 + 1

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic [15:0] buttons0;
    logic [15:0] buttons1;
    logic [1:0]  pad_present;
    logic [15:0] press0;
    logic [15:0] press1;
    logic [1:0]  press_clr = 2'b00;
    logic        frame_done;

    typedef struct {
        logic [15:0] b0;
        logic [15:0] b1;
        logic [15:0] p0;
        logic [15:0] p1;
        logic [1:0]  pres;
    } expFrame_t;

    expFrame_t sbq[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Pad models: active-high pressed words, loaded on the latch rising edge.
    logic [15:0] padBtn0 = 16'h0000;
    logic [15:0] padBtn1 = 16'h0000;
    logic [15:0] latchedBtn0 = 16'h0000;
    logic [15:0] latchedBtn1 = 16'h0000;
    logic        tieLow1 = 1'b0;
    logic [3:0]  padIdx = 4'd0;

    snes_pad_reader #(
        .POLL_DIV     (POLL_DIV),
        .LATCH_CYCLES (LATCH_CYCLES),
        .HALF_CYCLES  (HALF_CYCLES),
        .NUM_BITS     (NUM_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pad_data    (pad_data),
        .pad_latch   (pad_latch),
        .pad_clk     (pad_clk),
        .buttons0    (buttons0),
        .buttons1    (buttons1),
        .pad_present (pad_present),
        .press0      (press0),
        .press1      (press1),
        .press_clr   (press_clr),
        .frame_done  (frame_done)
    );

    always #20 clk = ~clk;

    // Edges seen since reset release.
    always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

    always @(posedge pad_latch) begin
        latchedBtn0 <= padBtn0;
        latchedBtn1 <= padBtn1;
        padIdx      <= 4'd0;
    end

    // The pad presents its next bit as soon as pad_clk drops.
    always @(negedge pad_clk) begin
        if (!pad_latch && padIdx != 4'd15) padIdx <= padIdx + 4'd1;
    end

    assign pad_data[0] = ~latchedBtn0[padIdx];
    assign pad_data[1] = tieLow1 ? 1'b0 : ~latchedBtn1[padIdx];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected {pad_latch, pad_clk} at a given cycle offset from latch rise.
    function automatic logic [1:0] waveAt(input int off);
        if (off < LATCH_CYCLES) return 2'b11;
        if (off < FRAME_LEN - 1)
            return (((off - LATCH_CYCLES) % (2 * HALF_CYCLES)) < HALF_CYCLES) ? 2'b00 : 2'b01;
        return 2'b01;
    endfunction

    // Monitor: each frame_done pops one expected frame.
    always @(negedge clk) begin : monitor
        expFrame_t e;
        if (reset && frame_done) begin
            if (sbq.size() == 0) begin
                check("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("buttons0", 32'(buttons0), 32'(e.b0));
                check("buttons1", 32'(buttons1), 32'(e.b1));
                check("press0", 32'(press0), 32'(e.p0));
                check("press1", 32'(press1), 32'(e.p1));
                check("pad_present", 32'(pad_present), 32'(e.pres));
            end
        end
    end

    task automatic resetValues(input string tag);
        check({tag, "_pad_latch"}, 32'(pad_latch), 32'd0);
        check({tag, "_pad_clk"}, 32'(pad_clk), 32'd1);
        check({tag, "_buttons"}, 32'({buttons1, buttons0}), 32'd0);
        check({tag, "_press"}, 32'({press1, press0}), 32'd0);
        check({tag, "_pad_present"}, 32'(pad_present), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // Waits (bounded) for pad_latch high at a falling edge; returns cyc then.
    task automatic waitLatch(output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!pad_latch && n < POLL_DIV + 100) begin
            @(negedge clk);
            n++;
        end
        if (!pad_latch) begin
            check("latch_timeout", 32'd0, 32'd1);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "pad_latch never rose");
        end
        lat = cyc;
    endtask

    task automatic runFrame(input string tag, input logic [15:0] b0, input logic [15:0] b1,
                            input logic [15:0] p0, input logic [15:0] p1, input logic [1:0] pres,
                            input int expLatch, input bit doWave, input bit clrInDone);
        expFrame_t e;
        int lat;
        e.b0 = b0; e.b1 = b1; e.p0 = p0; e.p1 = p1; e.pres = pres;
        sbq.push_back(e);
        waitLatch(lat);
        check({tag, "_latch_cycle"}, 32'(lat), 32'(expLatch));
        if (doWave) check({tag, "_wave"}, 32'({pad_latch, pad_clk}), 32'(waveAt(0)));
        for (int off = 1; off <= FRAME_LEN; off++) begin
            @(negedge clk);
            if (clrInDone && off == FRAME_LEN - 1) press_clr = 2'b01;
            if (clrInDone && off == FRAME_LEN) press_clr = 2'b00;
            if (doWave && off < FRAME_LEN) begin
                check({tag, "_wave"}, 32'({pad_latch, pad_clk}), 32'(waveAt(off)));
                check({tag, "_no_early_done"}, 32'(frame_done), 32'd0);
            end
        end
        check({tag, "_frame_done_time"}, 32'(frame_done), 32'd1);
    endtask

    initial begin : stimulus
        int lat;
        repeat (3) @(negedge clk);
        resetValues("reset");
        reset = 1'b1;

        // All released, both pads connected.
        runFrame("f1", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b11, 2000, 1'b1, 1'b0);

        // Pad0: A + Up; pad1: B.
        padBtn0 = 16'h0110;
        padBtn1 = 16'h0001;
        runFrame("f2", 16'h0110, 16'h0001, 16'h0110, 16'h0001, 2'b11, 4000, 1'b0, 1'b0);
        // Held buttons leave press bits unchanged.
        runFrame("f3", 16'h0110, 16'h0001, 16'h0110, 16'h0001, 2'b11, 6000, 1'b0, 1'b0);

        // Idle clear of pad1 only.
        repeat (5) @(negedge clk);
        press_clr = 2'b10;
        @(negedge clk);
        press_clr = 2'b00;
        check("idle_clr_press1", 32'(press1), 32'h0000);
        check("idle_clr_press0_kept", 32'(press0), 32'h0110);

        // Pad0 adds Start, clear coincident with DONE keeps only the new edge.
        padBtn0 = 16'h0118;
        runFrame("f4", 16'h0118, 16'h0001, 16'h0008, 16'h0000, 2'b11, 8000, 1'b0, 1'b1);

        // Pad1 unplugged: line held low.
        tieLow1 = 1'b1;
        runFrame("f5", 16'h0118, 16'h0000, 16'h0008, 16'h0000, 2'b01, 10000, 1'b0, 1'b0);

        // Pad1 back with R, pad0 holds all twelve buttons.
        tieLow1 = 1'b0;
        padBtn0 = 16'h0FFF;
        padBtn1 = 16'h0800;
        runFrame("f6", 16'h0FFF, 16'h0800, 16'h0EEF, 16'h0800, 2'b11, 12000, 1'b0, 1'b0);

        // Reset during CLK_HIGH of bit 7 aborts the frame.
        waitLatch(lat);
        check("abort_latch_cycle", 32'(lat), 32'd14000);
        repeat (30) @(negedge clk);
        check("abort_in_clk_high", 32'({pad_latch, pad_clk}), 32'b01);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        resetValues("abort");
        reset = 1'b1;
        runFrame("f8", 16'h0FFF, 16'h0800, 16'h0FFF, 16'h0800, 2'b11, 2000, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drain", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
